// File: rtl/signal_debouncer.sv
// signal_debouncer: synchronises signal_raw into clk and passes a new level only after STABLE_CYCLES agreeing samples.
// Define DEBOUNCE_BUSY_EN to add the registered busy output (high while a change is being qualified).
module signal_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter bit RESET_VALUE   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic signal_raw,
  output logic signal
`ifdef DEBOUNCE_BUSY_EN
  ,
  output logic busy
`endif
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  typedef enum logic {STABLE, CHECK} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0] cnt, cnt_n;
  logic sync, sig_n;
  assign sync = sync_q[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= {SYNC_STAGES{RESET_VALUE}};
    else sync_q <= {sync_q[SYNC_STAGES-2:0], signal_raw};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= STABLE;
      cnt    <= '0;
      signal <= RESET_VALUE;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      signal <= sig_n;
    end
  always_comb begin
    state_n = STABLE;
    cnt_n   = '0;
    sig_n   = signal;
    if (sync != signal) begin
      if (state == STABLE) begin
        if (STABLE_CYCLES == 1) sig_n = sync;
        else begin
          state_n = CHECK;
          cnt_n   = CW'(1);
        end
      end else if (cnt == CW'(STABLE_CYCLES - 1)) sig_n = sync;
      else begin
        state_n = CHECK;
        cnt_n   = cnt + CW'(1);
      end
    end
  end
`ifdef DEBOUNCE_BUSY_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= 1'b0;
    else busy <= (state_n == CHECK);
`endif
endmodule

// File: tb/tb_signal_debouncer.sv
// tb_signal_debouncer: three parameterisations driven by one raw line, checked against a run-length reference model via a scoreboard.
module tb_signal_debouncer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signal_raw = 1'b0;
  logic [2:0] sig;
  int ss[3] = '{2, 2, 3};
  int nn[3] = '{4, 1, 3};
  bit rv[3] = '{1'b0, 1'b0, 1'b1};
  int checks = 0;
  int errors = 0;
  bit [3:0] dl[3];
  bit msig[3];
  int run[3];
  bit [1:0] exq[3][$];
`ifdef DEBOUNCE_BUSY_EN
  logic [2:0] bsy;
  signal_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .RESET_VALUE(1'b0)) d0 (.clk(clk), .rst_n(rst_n), .signal_raw(signal_raw), .signal(sig[0]), .busy(bsy[0]));
  signal_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(1), .RESET_VALUE(1'b0)) d1 (.clk(clk), .rst_n(rst_n), .signal_raw(signal_raw), .signal(sig[1]), .busy(bsy[1]));
  signal_debouncer #(.SYNC_STAGES(3), .STABLE_CYCLES(3), .RESET_VALUE(1'b1)) d2 (.clk(clk), .rst_n(rst_n), .signal_raw(signal_raw), .signal(sig[2]), .busy(bsy[2]));
`else
  signal_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .RESET_VALUE(1'b0)) d0 (.clk(clk), .rst_n(rst_n), .signal_raw(signal_raw), .signal(sig[0]));
  signal_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(1), .RESET_VALUE(1'b0)) d1 (.clk(clk), .rst_n(rst_n), .signal_raw(signal_raw), .signal(sig[1]));
  signal_debouncer #(.SYNC_STAGES(3), .STABLE_CYCLES(3), .RESET_VALUE(1'b1)) d2 (.clk(clk), .rst_n(rst_n), .signal_raw(signal_raw), .signal(sig[2]));
`endif
  always #5 clk = ~clk;
  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      dl[i] = {4{rv[i]}};
      msig[i] = rv[i];
      run[i] = 0;
      exq[i].delete();
    end
  endtask
  // Reference: the FSM sees raw delayed by SYNC_STAGES edges; output flips after N consecutive differing samples.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else
        for (int i = 0; i < 3; i++) begin
          bit samp;
          samp = dl[i][ss[i]-1];
          dl[i] = {dl[i][2:0], signal_raw};
          if (samp != msig[i]) begin
            run[i]++;
            if (run[i] == nn[i]) begin
              msig[i] = samp;
              run[i] = 0;
            end
          end else run[i] = 0;
          exq[i].push_back({msig[i], run[i] > 0});
        end
    end
  end
  task automatic chk(string nm, int i, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %b expected %b at %0t", nm, i, act, exp, $time);
    end
  endtask
  initial
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        bit [1:0] e;
        e = (!rst_n || exq[i].size() == 0) ? {rv[i], 1'b0} : exq[i].pop_front();
        chk("signal", i, sig[i], e[1]);
`ifdef DEBOUNCE_BUSY_EN
        chk("busy", i, bsy[i], e[0]);
`endif
      end
    end
  task automatic hold(bit v, int n);
    signal_raw = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic async_reset(int pre, int len);
    #(pre) rst_n = 1'b0;
    #(len) rst_n = 1'b1;
    @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold(0, 10);
    hold(1, 20);
    hold(0, 20);
    hold(1, 3);
    hold(0, 10);
    for (int k = 0; k < 17; k++) hold(k[0] ? 1'b0 : 1'b1, 1);
    hold(1, 15);
    hold(0, 15);
    signal_raw = 1'b1;
    repeat (4) @(posedge clk);
    async_reset(1, 15);
    hold(1, 15);
    hold(0, 15);
    hold(1, 1);
    hold(0, 10);
    hold(1, 2);
    hold(0, 10);
    for (int k = 0; k < 400; k++) begin
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 7));
      if ($urandom_range(0, 40) == 0) async_reset($urandom_range(1, 9), $urandom_range(2, 25));
    end
    hold(0, 12);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
